// File: rtl/tmr_icb_ctrl.sv
// Bus-side register front end for a timer: decodes ICB commands into timer
// write strobes, returns readback data, and owns the overflow status,
// saturating overflow counter and interrupt enable.
module tmr_icb_ctrl #(
  parameter int OVF_CNT_W = 8
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        icb_cmd_valid,
  output logic        icb_cmd_ready,
  input  logic        icb_cmd_read,
  input  logic [2:0]  icb_cmd_addr,
  input  logic [15:0] icb_cmd_wdata,
  output logic        icb_rsp_valid,
  input  logic        icb_rsp_ready,
  output logic [15:0] icb_rsp_rdata,
  output logic        icb_rsp_err,
  output logic        tmr_con_wr,
  output logic        tmr_prd_wr,
  output logic        tmr_cnt_wr,
  output logic [15:0] icb_wdat,
  input  logic [15:0] tmr_con,
  input  logic [15:0] tmr_prd,
  input  logic [15:0] tmr_cnt,
  input  logic        tmr_ovf,
  output logic        tmr_irq
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [OVF_CNT_W-1:0] CNT_MAX = '1;

  state_t                state, state_nxt;
  logic                  lat_read;
  logic [2:0]            lat_addr;
  logic [1:0]            lat_ctl;
  logic [15:0]           wdat_q;
  logic [15:0]           rdata_q;
  logic                  err_q;
  logic                  ovf_pend;
  logic [OVF_CNT_W-1:0]  ovf_cnt;
  logic                  irq_en;

  logic                  hs;
  logic                  exec;
  logic                  wr_exec;
  logic                  mapped;
  logic                  clr_pend;
  logic                  clr_cnt;
  logic [15:0]           rd_src;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [OVF_CNT_W-1:0] sat_inc(input logic [OVF_CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + OVF_CNT_W'(1);
  endfunction

  // STAT word: pending flag in bit 0, counter from bit 8 upward, rest zero.
  function automatic logic [15:0] stat_word(input logic pend,
                                            input logic [OVF_CNT_W-1:0] cnt);
    logic [15:0] w;
    w = '0;
    w[0] = pend;
    w[8 +: OVF_CNT_W] = cnt;
    return w;
  endfunction

  assign hs       = icb_cmd_valid && (state == IDLE);
  assign exec     = (state == EXEC) && !sys_rst;
  assign wr_exec  = exec && !lat_read;
  assign mapped   = (lat_addr <= 3'd4);
  assign clr_pend = wr_exec && (lat_addr == 3'd3) && lat_ctl[0];
  assign clr_cnt  = wr_exec && (lat_addr == 3'd3) && lat_ctl[1];

  // Strobes and response flags are masked by reset so an aborted transaction
  // leaves no trace on the outputs.
  assign icb_cmd_ready = (state == IDLE) || sys_rst;
  assign icb_rsp_valid = (state == RESP) && !sys_rst;
  assign icb_rsp_rdata = rdata_q;
  assign icb_rsp_err   = err_q;
  assign icb_wdat      = wdat_q;
  assign tmr_con_wr    = wr_exec && (lat_addr == 3'd0);
  assign tmr_prd_wr    = wr_exec && (lat_addr == 3'd1);
  assign tmr_cnt_wr    = wr_exec && (lat_addr == 3'd2);
  assign tmr_irq       = ovf_pend && irq_en;

  // Readback source selection for the latched offset.
  always_comb begin
    rd_src = '0;
    case (lat_addr)
      3'd0:    rd_src = tmr_con;
      3'd1:    rd_src = tmr_prd;
      3'd2:    rd_src = tmr_cnt;
      3'd3:    rd_src = stat_word(ovf_pend, ovf_cnt);
      3'd4:    rd_src = {15'd0, irq_en};
      default: rd_src = '0;
    endcase
  end

  // Next-state logic: accept, execute for exactly one cycle, then respond.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (icb_cmd_valid) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (icb_rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  // Command capture; only the two low wdata bits are needed after EXEC decode.
  always_ff @(posedge sys_clk) begin
    if (hs) begin
      lat_read <= icb_cmd_read;
      lat_addr <= icb_cmd_addr;
      lat_ctl  <= icb_cmd_wdata[1:0];
    end
  end

  // Timer write data is loaded at acceptance so it is already valid while the
  // strobe fires in EXEC, and holds between timer writes.
  always_ff @(posedge sys_clk) begin
    if (sys_rst)
      wdat_q <= '0;
    else if (hs && !icb_cmd_read && (icb_cmd_addr <= 3'd2))
      wdat_q <= icb_cmd_wdata;
  end

  // Response capture in EXEC; held unchanged through RESP.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (exec) begin
      err_q   <= !mapped;
      rdata_q <= (lat_read && mapped) ? rd_src : 16'd0;
    end
  end

  // Overflow status: a coincident overflow beats a software clear.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      ovf_pend <= 1'b0;
      ovf_cnt  <= '0;
    end else if (tmr_ovf) begin
      ovf_pend <= 1'b1;
      ovf_cnt  <= clr_cnt ? OVF_CNT_W'(1) : sat_inc(ovf_cnt);
    end else begin
      if (clr_pend) ovf_pend <= 1'b0;
      if (clr_cnt)  ovf_cnt  <= '0;
    end
  end

  // Interrupt enable register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst)
      irq_en <= 1'b0;
    else if (wr_exec && (lat_addr == 3'd4))
      irq_en <= lat_ctl[0];
  end

endmodule
